// File: rtl/queue_enq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : queue_enq_arbiter
// Brief    : Round-robin arbiter sharing one valid/ready queue enqueue port
//            among NUM_REQ requesters. It has a registered output slot and an
//            optional burst lock.
// Revision : 1.0 - initial release
// ============================================================================
module queue_enq_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 1,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         enq_data,
    output logic                          enq_valid,
    input  logic                          enq_ready,
    output logic [ID_WIDTH-1:0]           enq_id,
    output logic                          locked
);

    localparam int                    c_CNT_WIDTH = $clog2(MAX_BURST + 1);
    localparam logic [0:0]            c_IDLE      = 1'b0;
    localparam logic [0:0]            c_LOCKED    = 1'b1;
    localparam logic [c_CNT_WIDTH-1:0] c_MAX_BURST = c_CNT_WIDTH'(MAX_BURST);
    localparam logic [ID_WIDTH-1:0]   c_LAST_ID   = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [ID_WIDTH:0]     c_NUM_REQ   = (ID_WIDTH + 1)'(NUM_REQ);

    logic [0:0]             r_state;
    logic [ID_WIDTH-1:0]    r_rr_ptr;
    logic [ID_WIDTH-1:0]    r_owner;
    logic [c_CNT_WIDTH-1:0] r_burst_cnt;
    logic                   r_enq_valid;
    logic [DATA_WIDTH-1:0]  r_enq_data;
    logic [ID_WIDTH-1:0]    r_enq_id;

    logic [DATA_WIDTH-1:0]  w_req_data [NUM_REQ];
    logic                   w_can_load;
    logic                   w_owner_hold;
    logic [ID_WIDTH-1:0]    w_owner_next;
    logic [ID_WIDTH-1:0]    w_scan_start;
    logic [ID_WIDTH:0]      w_sum;
    logic [ID_WIDTH-1:0]    w_idx;
    logic                   w_scan_hit;
    logic [ID_WIDTH-1:0]    w_scan_idx;
    logic                   w_have_winner;
    logic [ID_WIDTH-1:0]    w_winner;
    logic [ID_WIDTH-1:0]    w_winner_next;
    logic                   w_xfer;
    logic [NUM_REQ-1:0]     w_req_ready;
    logic [c_CNT_WIDTH-1:0] w_cnt_inc;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_can_load    = !r_enq_valid || enq_ready;
    assign w_owner_hold  = (r_state == c_LOCKED) && req_valid[r_owner];
    assign w_owner_next  = (r_owner == c_LAST_ID) ? '0 : r_owner + 1'b1;
    assign w_scan_start  = (r_state == c_LOCKED) ? w_owner_next : r_rr_ptr;
    assign w_cnt_inc     = r_burst_cnt + 1'b1;

    // Modulo scan works for any NUM_REQ, not just powers of two.
    always_comb begin
        w_scan_hit = 1'b0;
        w_scan_idx = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, w_scan_start} + (ID_WIDTH + 1)'(k);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            w_idx = w_sum[ID_WIDTH-1:0];
            if (!w_scan_hit && req_valid[w_idx]) begin
                w_scan_hit = 1'b1;
                w_scan_idx = w_idx;
            end
        end
    end

    assign w_have_winner = w_owner_hold || w_scan_hit;
    assign w_winner      = w_owner_hold ? r_owner : w_scan_idx;
    assign w_winner_next = (w_winner == c_LAST_ID) ? '0 : w_winner + 1'b1;
    assign w_xfer        = !reset && w_have_winner && w_can_load;

    always_comb begin
        w_req_ready = '0;
        if (w_xfer) begin
            w_req_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_enq_valid <= 1'b0;
            r_enq_data  <= '0;
            r_enq_id    <= '0;
        end else begin
            if (w_xfer) begin
                r_enq_data  <= w_req_data[w_winner];
                r_enq_id    <= w_winner;
                r_enq_valid <= 1'b1;
            end else if (r_enq_valid && enq_ready) begin
                r_enq_valid <= 1'b0;
            end

            if (w_owner_hold) begin
                // Owner keeps the grant; a stalled owner holds everything.
                if (w_xfer) begin
                    if (w_cnt_inc == c_MAX_BURST) begin
                        r_state     <= c_IDLE;
                        r_rr_ptr    <= w_owner_next;
                        r_burst_cnt <= '0;
                    end else begin
                        r_burst_cnt <= w_cnt_inc;
                    end
                end
            end else if (w_xfer) begin
                if (MAX_BURST == 1) begin
                    r_state  <= c_IDLE;
                    r_rr_ptr <= w_winner_next;
                end else begin
                    r_state     <= c_LOCKED;
                    r_owner     <= w_winner;
                    r_burst_cnt <= c_CNT_WIDTH'(1);
                end
            end else if (r_state == c_LOCKED) begin
                r_state     <= c_IDLE;
                r_rr_ptr    <= w_owner_next;
                r_burst_cnt <= '0;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign enq_data  = r_enq_data;
    assign enq_valid = r_enq_valid;
    assign enq_id    = r_enq_id;
    assign locked    = (r_state == c_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_queue_enq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_enq_arbiter
// Brief    : Directed bench for queue_enq_arbiter with MAX_BURST = 1, 2 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_enq_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req_data;
    logic [3:0]  req_valid;
    logic        enq_ready;

    logic [3:0] rdy1, rdy2, rdy4;
    logic [3:0] dat1, dat2, dat4;
    logic       val1, val2, val4;
    logic [1:0] id1, id2, id4;
    logic       lck1, lck2, lck4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    queue_enq_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
        .req_ready(rdy1), .enq_data(dat1), .enq_valid(val1), .enq_ready(enq_ready),
        .enq_id(id1), .locked(lck1));

    queue_enq_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .MAX_BURST(2)) u_dut2 (
        .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
        .req_ready(rdy2), .enq_data(dat2), .enq_valid(val2), .enq_ready(enq_ready),
        .enq_id(id2), .locked(lck2));

    queue_enq_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
        .req_ready(rdy4), .enq_data(dat4), .enq_valid(val4), .enq_ready(enq_ready),
        .enq_id(id4), .locked(lck4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        enq_ready = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        enq_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if (val1 !== 1'b0 || rdy1 !== 4'b0000 || lck1 !== 1'b0 || id1 !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state cyc%0d: valid=%b ready=%b locked=%b id=%0d, want 0 0000 0 0",
                         c, val1, rdy1, lck1, id1);
            end
            n_cmp++;
            if (lck2 !== 1'b0 || lck4 !== 1'b0 || rdy4 !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_burst_duts cyc%0d: lck2=%b lck4=%b rdy4=%b, want 0 0 0000",
                         c, lck2, lck4, rdy4);
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rdy1 !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: req_ready=%b, want 0001", rdy1);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (rdy1 !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: req_ready=%b, want 0001", rdy1);
        end
        step();
        req_valid = 4'b0000;
        n_cmp++;
        if (val1 !== 1'b1 || dat1 !== 4'h1 || id1 !== 2'd0) begin
            n_fail++;
            $display("FAIL single_enq: valid=%b data=%h id=%0d, want 1 1 0", val1, dat1, id1);
        end
        step();
        n_cmp++;
        if (val1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: enq_valid=%b, want 0", val1);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [5];
        logic [3:0] exp_d  [5];
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (val1 !== 1'b1 || id1 !== exp_id[k] || dat1 !== exp_d[k]) begin
                n_fail++;
                $display("FAIL rr_beat%0d: valid=%b id=%0d data=%h, want 1 %0d %h",
                         k, val1, id1, dat1, exp_id[k], exp_d[k]);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b1111;
        step();
        step();
        enq_ready = 1'b0;
        #1;
        n_cmp++;
        if (rdy1 !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_ready_low: req_ready=%b, want 0000", rdy1);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (val1 !== 1'b1 || dat1 !== 4'h2 || id1 !== 2'd1 || rdy1 !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d: valid=%b data=%h id=%0d ready=%b, want 1 2 1 0000",
                         c, val1, dat1, id1, rdy1);
            end
        end
        enq_ready = 1'b1;
        #1;
        n_cmp++;
        if (rdy1 !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_resume_ready: req_ready=%b, want 0100", rdy1);
        end
        step();
        n_cmp++;
        if (val1 !== 1'b1 || id1 !== 2'd2 || dat1 !== 4'h3) begin
            n_fail++;
            $display("FAIL bp_resume_enq: valid=%b id=%0d data=%h, want 1 2 3", val1, id1, dat1);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_burst();
        logic [1:0] exp_id2 [5];
        logic       exp_lk2 [5];
        logic [1:0] exp_id1 [5];
        exp_id2 = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
        exp_lk2 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_id1 = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
        do_reset();
        req_valid = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (val2 !== 1'b1 || id2 !== exp_id2[k] || lck2 !== exp_lk2[k]) begin
                n_fail++;
                $display("FAIL burst2_beat%0d: valid=%b id=%0d locked=%b, want 1 %0d %b",
                         k, val2, id2, lck2, exp_id2[k], exp_lk2[k]);
            end
            n_cmp++;
            if (id1 !== exp_id1[k] || lck1 !== 1'b0) begin
                n_fail++;
                $display("FAIL burst1_beat%0d: id=%0d locked=%b, want %0d 0",
                         k, id1, lck1, exp_id1[k]);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_early_release();
        do_reset();
        req_valid = 4'b0011;
        step();
        n_cmp++;
        if (id4 !== 2'd0 || lck4 !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_first: id=%0d locked=%b, want 0 1", id4, lck4);
        end
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (rdy4 !== 4'b0010) begin
            n_fail++;
            $display("FAIL rel_same_cycle: req_ready=%b, want 0010", rdy4);
        end
        step();
        n_cmp++;
        if (id4 !== 2'd1 || dat4 !== 4'h2 || lck4 !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_new_owner: id=%0d data=%h locked=%b, want 1 2 1", id4, dat4, lck4);
        end
        req_valid = 4'b0011;
        #1;
        n_cmp++;
        if (rdy4 !== 4'b0010) begin
            n_fail++;
            $display("FAIL rel_owner_kept: req_ready=%b, want 0010", rdy4);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if (lck4 !== 1'b0 || val4 !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_mid_reset: locked=%b valid=%b, want 0 0", lck4, val4);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rdy4 !== 4'b0001) begin
            n_fail++;
            $display("FAIL rel_post_reset_grant: req_ready=%b, want 0001", rdy4);
        end
        req_valid = 4'b0000;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        enq_ready = 1'b1;
        req_data  = {4'h4, 4'h3, 4'h2, 4'h1};
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_burst();
        test_early_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/queue_enq_arbiter.md
Name: queue_enq_arbiter

Overview:
- Round-robin arbiter that shares the enqueue side of one valid/ready queue (QueueWrapper-style: din, enq_val, enq_rdy) among NUM_REQ requesters.
- Registered output slot decouples requester timing from the queue.
- Optional burst lock lets a winner push up to MAX_BURST beats before the grant rotates.
- Sits directly in front of the queue's enq port; enq_id tags each beat with its source.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 4, beat width; matches queue din/dout.
- MAX_BURST, 1, max consecutive beats per grant; 1 = pure round-robin, LOCKED state never entered.
- ID_WIDTH, clog2(NUM_REQ), width of enq_id.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_data  in  NUM_REQ*DATA_WIDTH  packed requester data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester ready; one-hot or zero.
- enq_data  out  DATA_WIDTH  to queue din.
- enq_valid  out  1  to queue enq_val.
- enq_ready  in  1  from queue enq_rdy.
- enq_id  out  ID_WIDTH  source index of the current enq_data.
- locked  out  1  high while in LOCKED state.

Behaviour:
- Reset, synchronous and active-high, overrides everything, including mid-burst:
  - enq_valid=0, enq_data=0, enq_id=0, locked=0.
  - rr_ptr=0, burst_cnt=0, state=IDLE.
  - A held output beat is discarded.
- Output slot:
  - can_load = !enq_valid || enq_ready.
  - A transfer from requester w occurs when req_valid[w] && req_ready[w].
  - On transfer: enq_data<=req_data[w], enq_id<=w, enq_valid<=1.
  - If enq_valid && enq_ready and no transfer: enq_valid<=0.
  - Latency: requester handshake in cycle N gives enq_valid in cycle N+1.
  - enq_data and enq_id are held stable while enq_valid && !enq_ready.
- Grant (combinational, from current state):
  - IDLE: winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - LOCKED with req_valid[owner]=1: winner = owner; no other requester considered.
  - LOCKED with req_valid[owner]=0: release the same cycle. Arbitrate as in IDLE with scan start owner+1 mod NUM_REQ; no bubble cycle.
  - req_ready[winner] = can_load; all other bits 0.
  - No valid requester: req_ready = 0.
  - req_ready depends combinationally on req_valid and enq_ready. Requesters must not make valid depend on ready.
- State update on a transfer from w:
  - From IDLE, MAX_BURST=1: rr_ptr<=w+1 mod NUM_REQ; stay IDLE.
  - From IDLE, MAX_BURST>1: owner<=w, burst_cnt<=1, state<=LOCKED.
  - From LOCKED, owner transfers: burst_cnt++. If the new count equals MAX_BURST: state<=IDLE, rr_ptr<=owner+1, burst_cnt<=0.
  - LOCKED release with a new winner w: handled as an IDLE grant to w (the two IDLE cases above).
  - LOCKED release with no winner: state<=IDLE, rr_ptr<=owner+1, burst_cnt<=0.
- Stall:
  - LOCKED with owner valid but !can_load: hold state, count and grant; no release.
  - IDLE with !can_load: rr_ptr unchanged.
- Wrap-around: rr_ptr and scan indices wrap modulo NUM_REQ. This holds for NUM_REQ not a power of two.
- locked = (state==LOCKED), registered.

Test Plan:
- Reset: assert reset 2 cycles with all req_valid=1111 -> enq_valid=0, req_ready=0000, locked=0, enq_id=0 throughout. First post-reset grant goes to requester 0.
- Single requester: req_valid=0001, req_data[3:0]=0x1, enq_ready=1 -> req_ready=0001 same cycle. Next cycle enq_valid=1, enq_data=0x1, enq_id=0.
- Round-robin, MAX_BURST=1: req_valid=1111 held, data i=i+1, enq_ready=1 -> enq_id sequence 0,1,2,3,0 on consecutive cycles, enq_data 1,2,3,4,1.
- Backpressure: slot holds 0x2 (id 1), enq_ready=0 for 3 cycles -> req_ready=0000, enq_data=0x2 and enq_id=1 stable. enq_ready=1 -> next grant goes to requester 2.
- Burst, MAX_BURST=2: req_valid=0101, enq_ready=1 -> enq_id 0,0,2,2,0. locked=1 after each burst's first beat, 0 after its second.
- Early release plus reset, MAX_BURST=4: requester 0 sends one beat then drops valid while req_valid[1]=1 -> req_ready=0010 that same cycle, owner becomes 1. Assert reset mid-burst -> locked=0, enq_valid=0 next cycle, next grant to requester 0.
